timer_countdown_core: RTL



---
 rtl/timer_pkg.sv | 17 +
 rtl/bcd_digit.sv | 40 ++++
 rtl/timer_countdown_core.sv | 120 ++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the kitchen-timer countdown engine.
// Holds the FSM state encoding, the BCD digit width and the per-digit
// maximum values used by the mm:ss digit cascade.
package timer_pkg;

  localparam int BCD_W        = 4;
  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

  typedef enum logic [1:0] {
    ST_SET    = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit counting 0..MAX.
// Ports:
//   clk, reset : clock and asynchronous active-high reset (digit -> 0)
//   clr        : synchronous clear to 0, wins over inc/dec
//   inc / dec  : increment / decrement enables, wrapping at MAX / 0
//   q          : current digit value
//   co / bo    : carry / borrow out, asserted in the cycle the digit wraps
module bcd_digit
  import timer_pkg::*;
#(
  parameter int MAX = DIGIT_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             co,
  output logic             bo
);

  localparam logic [BCD_W-1:0] QMAX = BCD_W'(MAX);

  assign co = inc && (q == QMAX);
  assign bo = dec && (q == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= (q == QMAX) ? '0 : q + BCD_W'(1);
    end else if (dec) begin
      q <= (q == '0) ? QMAX : q - BCD_W'(1);
    end
  end

endmodule

// File: rtl/timer_countdown_core.sv
// BCD mm:ss countdown engine for the kitchen timer.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   tick                : 1 Hz single-cycle enable
//   start_p, pause_p,
//   min_p, sec_p        : single-cycle debounced button pulses
//   bcd3..bcd0          : minutes tens/ones, seconds tens/ones (registered)
//   running, done       : status flags for RUN / DONE (registered)
//   alarm               : blink output, 1 on DONE entry, toggles per tick
module timer_countdown_core
  import timer_pkg::*;
#(
  parameter int MAX_MIN     = 99,
  parameter int ALARM_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start_p,
  input  logic             pause_p,
  input  logic             min_p,
  input  logic             sec_p,
  output logic [BCD_W-1:0] bcd3,
  output logic [BCD_W-1:0] bcd2,
  output logic [BCD_W-1:0] bcd1,
  output logic [BCD_W-1:0] bcd0,
  output logic             running,
  output logic             done,
  output logic             alarm
);

  localparam int CNT_W = (ALARM_TICKS > 0) ? $clog2(ALARM_TICKS + 1) : 1;

  state_t           state_q, state_n;
  logic [CNT_W-1:0] alarm_cnt;

  logic s0_co, s0_bo, s1_bo, m0_co, m0_bo;
  logic unused_s1_co, unused_m1_co, unused_m1_bo;

  logic set_edit, sec_inc, min_inc, cnt_dn, mm_at_max, min_wrap;
  logic is_zero, is_one, any_btn, alarm_expire;

  // Edits only apply in SET, and a start press in the same cycle masks them.
  assign set_edit  = (state_q == ST_SET) && !start_p;
  assign sec_inc   = set_edit && sec_p;
  assign min_inc   = set_edit && min_p;
  assign cnt_dn    = (state_q == ST_RUN) && tick;
  assign mm_at_max = (bcd3 == BCD_W'(MAX_MIN / 10)) && (bcd2 == BCD_W'(MAX_MIN % 10));
  assign min_wrap  = min_inc && mm_at_max;

  assign is_zero = (bcd3 == '0) && (bcd2 == '0) && (bcd1 == '0) && (bcd0 == '0);
  assign is_one  = (bcd3 == '0) && (bcd2 == '0) && (bcd1 == '0) && (bcd0 == BCD_W'(1));
  assign any_btn = start_p || pause_p || min_p || sec_p;
  assign alarm_expire = (ALARM_TICKS != 0) && (alarm_cnt == CNT_W'(ALARM_TICKS - 1));

  // Seconds: the tens-digit carry is dropped so 59 -> 00 never touches minutes.
  // Borrows always ripple, because RUN can never sit at 00:00.
  bcd_digit #(.MAX(DIGIT_MAX)) u_s0 (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(sec_inc), .dec(cnt_dn),
    .q(bcd0), .co(s0_co), .bo(s0_bo)
  );
  bcd_digit #(.MAX(SEC_TENS_MAX)) u_s1 (
    .clk(clk), .reset(reset), .clr(1'b0), .inc(s0_co), .dec(s0_bo),
    .q(bcd1), .co(unused_s1_co), .bo(s1_bo)
  );
  // Minutes: MAX_MIN may not end in 99, so the pair is cleared explicitly.
  bcd_digit #(.MAX(DIGIT_MAX)) u_m0 (
    .clk(clk), .reset(reset), .clr(min_wrap), .inc(min_inc), .dec(s1_bo),
    .q(bcd2), .co(m0_co), .bo(m0_bo)
  );
  bcd_digit #(.MAX(DIGIT_MAX)) u_m1 (
    .clk(clk), .reset(reset), .clr(min_wrap), .inc(m0_co), .dec(m0_bo),
    .q(bcd3), .co(unused_m1_co), .bo(unused_m1_bo)
  );

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_SET:    if (start_p && !is_zero) state_n = ST_RUN;
      ST_RUN: begin
        // Reaching 00:00 wins over a simultaneous pause press.
        if (tick && is_one)  state_n = ST_DONE;
        else if (pause_p)    state_n = ST_PAUSED;
      end
      ST_PAUSED: if (start_p || pause_p) state_n = ST_RUN;
      ST_DONE: begin
        if (any_btn)                   state_n = ST_SET;
        else if (tick && alarm_expire) state_n = ST_SET;
      end
      default:   state_n = ST_SET;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_SET;
      running   <= 1'b0;
      done      <= 1'b0;
      alarm     <= 1'b0;
      alarm_cnt <= '0;
    end else begin
      state_q <= state_n;
      running <= (state_n == ST_RUN);
      done    <= (state_n == ST_DONE);
      if (state_n == ST_DONE) begin
        if (state_q != ST_DONE) begin
          alarm     <= 1'b1;
          alarm_cnt <= '0;
        end else if (tick) begin
          alarm     <= ~alarm;
          alarm_cnt <= alarm_cnt + CNT_W'(1);
        end
      end else begin
        alarm     <= 1'b0;
        alarm_cnt <= '0;
      end
    end
  end

endmodule
